// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared definitions for the RV32IM M-extension execute unit:
//          funct3 operation codes, FSM state encoding and operand
//          signedness helpers.
// Ports  : (package - none)
// Rev    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV)  || (op == MULDIV_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM only
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module : muldiv_step
// Brief  : One radix-2 iteration, purely combinational.
//          Multiply: shift-add on the {acc_in, low_in} product register,
//                    low_in holds the not-yet-consumed multiplier bits.
//          Divide  : restoring step; acc_in is the partial remainder,
//                    low_in shifts dividend bits out and quotient bits in.
// Ports  : mode_div  in   1     0 = multiply, 1 = divide
//          acc_in    in   XLEN  accumulator / partial remainder
//          opnd      in   XLEN  multiplicand / divisor magnitude
//          low_in    in   XLEN  multiplier / dividend-quotient register
//          acc_out   out  XLEN  next accumulator
//          low_out   out  XLEN  next low register
// Rev    : 1.0 - initial release
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            mode_div,
  input  logic [XLEN-1:0] acc_in,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] low_in,
  output logic [XLEN-1:0] acc_out,
  output logic [XLEN-1:0] low_out
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic          w_ge;

  always_comb begin
    w_sum     = {1'b0, acc_in} + {1'b0, opnd};
    w_shifted = {acc_in, low_in[XLEN-1]};
    // Partial remainder is always below the divisor, so the shifted value
    // fits XLEN+1 bits and the post-subtract value fits XLEN bits.
    w_ge      = (w_shifted >= {1'b0, opnd});
    acc_out   = acc_in;
    low_out   = low_in;
    if (mode_div) begin
      if (w_ge) begin
        acc_out = w_shifted[XLEN-1:0] - opnd;
        low_out = {low_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = w_shifted[XLEN-1:0];
        low_out = {low_in[XLEN-2:0], 1'b0};
      end
    end else if (low_in[0]) begin
      // add multiplicand, then shift the whole product right by one
      acc_out = w_sum[XLEN:1];
      low_out = {w_sum[0], low_in[XLEN-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[XLEN-1:1]};
      low_out = {acc_in[0], low_in[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Multi-cycle RV32IM M-extension execute unit (MUL/MULH/MULHSU/
//          MULHU/DIV/DIVU/REM/REMU). Operands are reduced to magnitudes on
//          accept, XLEN radix-2 iterations run in CALC, the sign is restored
//          in FIX. Divide-by-zero and signed overflow complete immediately.
// Ports  : clk      in   1      clock, rising edge
//          rst_n    in   1      synchronous active-low reset
//          start    in   1      request, accepted in IDLE or DONE
//          flush    in   1      kill in-flight op (wins over start)
//          op       in   3      funct3 operation select
//          tag_in   in   TAG_W  destination tag captured with operands
//          a, b     in   XLEN   rs1 / rs2 operands
//          busy     out  1      high in CALC and FIX
//          done     out  1      one-cycle completion pulse
//          result   out  XLEN   result of last completed op
//          tag_out  out  TAG_W  tag of last completed op
// Rev    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int                CNT_W      = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]   c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state;
  logic [2:0]         r_op;
  logic [TAG_W-1:0]   r_tag;
  logic [XLEN-1:0]    r_acc;
  logic [XLEN-1:0]    r_low;
  logic [XLEN-1:0]    r_opnd;
  logic               r_neg;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sa, w_sb;
  logic [XLEN-1:0]    w_abs_a, w_abs_b;
  logic               w_neg;
  logic               w_div0, w_ovf;
  logic [XLEN-1:0]    w_special_res;
  logic [XLEN-1:0]    w_acc_next, w_low_next;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_qr;
  logic [XLEN-1:0]    w_fix_res;
  logic               w_accept;

  // ---------------- accept-side operand conditioning ----------------
  always_comb begin
    w_sa    = is_signed_a(op);
    w_sb    = is_signed_b(op);
    w_abs_a = (w_sa && a[XLEN-1]) ? (-a) : a;
    w_abs_b = (w_sb && b[XLEN-1]) ? (-b) : b;
    // remainder takes the dividend's sign; everything else is the xor
    if (op[2] && op[1])
      w_neg = w_sa && a[XLEN-1];
    else
      w_neg = (w_sa && a[XLEN-1]) ^ (w_sb && b[XLEN-1]);
    w_div0  = op[2] && (b == '0);
    // only DIV (100) and REM (110) are signed divides
    w_ovf   = op[2] && !op[0] && (a == c_most_neg) && (b == '1);
    if (w_div0)
      w_special_res = op[1] ? a : '1;
    else
      w_special_res = op[1] ? '0 : a;
    w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .mode_div (r_op[2]),
    .acc_in   (r_acc),
    .opnd     (r_opnd),
    .low_in   (r_low),
    .acc_out  (w_acc_next),
    .low_out  (w_low_next)
  );

  // ---------------- sign correction and result select ----------------
  always_comb begin
    w_prod = {r_acc, r_low};
    if (r_neg)
      w_prod = -w_prod;
    w_qr = r_op[1] ? r_acc : r_low;
    if (r_neg)
      w_qr = -w_qr;
    if (r_op[2])
      w_fix_res = w_qr;
    else if (r_op == MULDIV_MUL)
      w_fix_res = w_prod[XLEN-1:0];
    else
      w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  // ---------------- control FSM and registered outputs ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_tag   <= '0;
      r_acc   <= '0;
      r_low   <= '0;
      r_opnd  <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      tag_out <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (w_accept) begin
            r_op   <= op;
            r_tag  <= tag_in;
            r_acc  <= '0;
            r_low  <= w_abs_a;
            r_opnd <= w_abs_b;
            r_neg  <= w_neg;
            r_cnt  <= '0;
            if (w_div0 || w_ovf) begin
              result  <= w_special_res;
              tag_out <= tag_in;
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ST_CALC;
              busy    <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_low <= w_low_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_cnt_last)
            r_state <= ST_FIX;
        end
        ST_FIX: begin
          result  <= w_fix_res;
          tag_out <= r_tag;
          r_state <= ST_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Self-checking bench for muldiv_unit (XLEN=32). A behavioural
//          model built on plain 64-bit arithmetic predicts each completed
//          result; a monitor compares every done pulse against it, and the
//          directed vectors also carry hand-computed literals, latencies
//          and busy durations.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [4:0]  tag_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN  (32),
    .TAG_W (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .tag_in  (tag_in),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];
  exp_t m_e;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  // Reference result straight from the RISC-V M-extension definitions
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, p;
    int sx, sy;
    logic ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    ex  = is_signed_a(o) ? {{32{x[31]}}, x} : {32'd0, x};
    ey  = is_signed_b(o) ? {{32{y[31]}}, y} : {32'd0, y};
    p   = ex * ey;
    case (o)
      MULDIV_MUL:                              return p[31:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: return p[63:32];
      MULDIV_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? x  : 32'(sx / sy);
      MULDIV_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      MULDIV_REM:  return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
      default:     return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return 1'b0;
    if (y == 0) return 1'b1;
    return (o == MULDIV_DIV || o == MULDIV_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  // Monitor: every done pulse must match the oldest predicted completion
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check32("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        check32("model_result", result, m_e.res);
        check32("model_tag", {27'd0, tag_out}, {27'd0, m_e.tag});
      end
    end
  end

  // Drive a request for one cycle (call at a negedge); operands are
  // scrambled afterwards since they only need to be valid when accepted.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input bit push);
    exp_t e;
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    tag_in = t;
    if (push) begin
      e.res = ref_res(o, x, y);
      e.tag = t;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 3'($urandom_range(0, 7));
    a      = $urandom;
    b      = $urandom;
    tag_in = 5'($urandom_range(0, 31));
  endtask

  // Count negedges after the accepting edge until done is seen.
  task automatic wait_done(input string name, input int exp_lat, input int k0,
                           input int exp_busy, input logic [31:0] lit);
    int  k;
    int  bc;
    bit  seen;
    k    = k0;
    bc   = 0;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      k++;
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check32({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check32({name, "_latency"}, 32'(k), 32'(exp_lat));
      if (exp_busy >= 0) check32({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
      check32({name, "_result"}, result, lit);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [4:0] t, input logic [31:0] lit);
    bit sp;
    sp = is_special(o, x, y);
    @(negedge clk);
    launch(o, x, y, t, 1'b1);
    wait_done(name, sp ? 1 : 34, 0, sp ? 0 : 33, lit);
  endtask

  int saved_done;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 3'd0;
    tag_in = 5'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_busy",    {31'd0, busy}, 32'd0);
    check32("reset_done",    {31'd0, done}, 32'd0);
    check32("reset_result",  result, 32'd0);
    check32("reset_tag",     {27'd0, tag_out}, 32'd0);
    rst_n = 1'b1;

    // main function, hand-computed literals
    run("mul",       MULDIV_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run("mulh",      MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    run("mulhsu",    MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF);
    run("mulhu",     MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE);
    run("div",       MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD);
    run("rem",       MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF);
    run("divu",      MULDIV_DIVU,   32'd100,       32'd7,         5'd11, 32'd14);
    run("remu",      MULDIV_REMU,   32'd100,       32'd7,         5'd12, 32'd2);
    run("rem_negdiv",MULDIV_REM,    32'd100,       32'hFFFF_FFF9, 5'd13, 32'd2);
    run("mul_big",   MULDIV_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 32'h242D_2080);
    // special cases: immediate completion
    run("divu_by0",  MULDIV_DIVU,   32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF);
    run("div_by0",   MULDIV_DIV,    32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF);
    run("rem_by0",   MULDIV_REM,    32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFF9);
    run("rem_ovf",   MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
    run("div_ovf",   MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);

    // flush at cycle 10 with a competing start: nothing completes, outputs hold
    @(negedge clk);
    launch(MULDIV_DIV, 32'd1000, 32'd3, 5'd20, 1'b0);
    repeat (9) @(negedge clk);
    flush  = 1'b1;
    start  = 1'b1;
    op     = MULDIV_DIVU;
    a      = 32'd50;
    b      = 32'd5;
    tag_in = 5'd21;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check32("flush_busy",   {31'd0, busy}, 32'd0);
    check32("flush_done",   {31'd0, done}, 32'd0);
    check32("flush_result", result, 32'h8000_0000);
    check32("flush_tag",    {27'd0, tag_out}, 32'd11);
    saved_done = done_cnt;
    repeat (40) @(negedge clk);
    check32("flush_no_done", 32'(done_cnt), 32'(saved_done));
    run("after_flush", MULDIV_DIVU, 32'd1000, 32'd10, 5'd22, 32'd100);

    // start while busy is ignored
    @(negedge clk);
    launch(MULDIV_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    op     = MULDIV_MUL;
    a      = 32'd3;
    b      = 32'd4;
    tag_in = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start", 34, 4, -1, 32'hFFFF_FFFE);

    // back-to-back: start asserted in the DONE cycle
    launch(MULDIV_DIVU, 32'd100, 32'd7, 5'd2, 1'b1);
    wait_done("back_to_back", 34, 0, 33, 32'd14);
    launch(MULDIV_REMU, 32'd9, 32'd0, 5'd3, 1'b1);
    wait_done("b2b_special", 1, 0, 0, 32'd9);

    // reset in the middle of CALC clears everything, including result
    @(negedge clk);
    launch(MULDIV_MUL, 32'd5, 32'd6, 5'd4, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check32("midreset_busy",   {31'd0, busy}, 32'd0);
    check32("midreset_done",   {31'd0, done}, 32'd0);
    check32("midreset_result", result, 32'd0);
    check32("midreset_tag",    {27'd0, tag_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset", MULDIV_MUL, 32'd5, 32'd6, 5'd19, 32'd30);

    repeat (3) @(negedge clk);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
